// File: rtl/cdb_broadcaster_pkg.sv
// rtl/cdb_broadcaster_pkg.sv - shared widths, CDB packet type and index helper
package cdb_broadcaster_pkg;

  localparam int CDB_PHYS_REGS = 128;
  localparam int CDB_ROB_DEPTH = 64;
  localparam int CDB_XLEN      = 32;
  localparam int CDB_TAG_W     = $clog2(CDB_PHYS_REGS);
  localparam int CDB_ROB_W     = $clog2(CDB_ROB_DEPTH);

  // One completing result as seen by every CDB consumer.
  typedef struct packed {
    logic [CDB_TAG_W-1:0] tag;
    logic [CDB_XLEN-1:0]  value;
    logic [CDB_ROB_W-1:0] rob_idx;
    logic                 br_tag;
  } cdb_packet_t;

  // (base + off) mod n, for base < n and off < n.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/cdb_broadcaster_rr_multi_select.sv
// rtl/cdb_broadcaster_rr_multi_select.sv - round-robin select of up to W requesters into W lanes
module cdb_broadcaster_rr_multi_select
  import cdb_broadcaster_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        req,
  input  logic [PW-1:0]       rr_ptr,
  output logic [N-1:0]        grant,
  output logic [W-1:0][N-1:0] lane_sel,
  output logic [PW-1:0]       next_ptr
);

  // Scan from rr_ptr upward; winners fill lanes 0,1,.. in scan order and the
  // pointer moves just past the last winner (holds when nothing is granted).
  always_comb begin
    int cnt;
    int idx;
    grant    = '0;
    lane_sel = '0;
    next_ptr = rr_ptr;
    cnt      = 0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = wrap_idx(int'(rr_ptr), i, N);
      if (req[idx] && (cnt < W)) begin
        grant[idx]         = 1'b1;
        lane_sel[cnt][idx] = 1'b1;
        cnt                = cnt + 1;
        next_ptr           = PW'(wrap_idx(idx, 1, N));
      end
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// rtl/cdb_broadcaster.sv - per-FU holding slots, round-robin CDB arbitration and registered broadcast
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int PHYS_REGS = CDB_PHYS_REGS,
  parameter int ROB_DEPTH = CDB_ROB_DEPTH,
  parameter int XLEN      = CDB_XLEN,
  parameter int FU_NUM    = 4,
  parameter int CDB_WIDTH = 2
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [FU_NUM-1:0]                             fu_valid_i,
  input  cdb_packet_t [FU_NUM-1:0]                      fu_pkt_i,
  output logic [FU_NUM-1:0]                             fu_ready_o,
  input  logic                                          squash_i,
  input  logic                                          clear_br_tag_i,
  output logic [CDB_WIDTH-1:0]                          cdb_valid_o,
  output logic [CDB_WIDTH-1:0][$clog2(PHYS_REGS)-1:0]   cdb_tag_o,
  output logic [CDB_WIDTH-1:0][XLEN-1:0]                cdb_value_o,
  output logic [CDB_WIDTH-1:0][$clog2(ROB_DEPTH)-1:0]   cdb_rob_idx_o
);

  localparam int PW    = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
  localparam int TAG_W = $clog2(PHYS_REGS);
  localparam int ROB_W = $clog2(ROB_DEPTH);

  logic [FU_NUM-1:0]                  pending;
  cdb_packet_t [FU_NUM-1:0]           slot_pkt;
  logic [PW-1:0]                      rr_ptr;
  logic [PW-1:0]                      next_ptr;
  logic [FU_NUM-1:0]                  slot_br;
  logic [FU_NUM-1:0]                  req;
  logic [FU_NUM-1:0]                  grant;
  logic [FU_NUM-1:0]                  capture;
  logic [CDB_WIDTH-1:0][FU_NUM-1:0]   lane_sel;
  logic                               clear_now;

  logic [CDB_WIDTH-1:0]               lane_valid;
  logic [CDB_WIDTH-1:0][TAG_W-1:0]    lane_tag;
  logic [CDB_WIDTH-1:0][XLEN-1:0]     lane_value;
  logic [CDB_WIDTH-1:0][ROB_W-1:0]    lane_rob;

  // Squash has priority over a simultaneous clear.
  assign clear_now = clear_br_tag_i && !squash_i;

  // Speculative slots sit out arbitration during a squash.
  always_comb begin
    for (int k = 0; k < FU_NUM; k++) slot_br[k] = slot_pkt[k].br_tag;
  end

  assign req        = pending & ~(squash_i ? slot_br : '0);
  assign fu_ready_o = ~pending | grant;

  // A slot captures when ready, except for speculative results arriving during a squash.
  always_comb begin
    for (int k = 0; k < FU_NUM; k++)
      capture[k] = fu_valid_i[k] && fu_ready_o[k] && !(squash_i && fu_pkt_i[k].br_tag);
  end

  cdb_broadcaster_rr_multi_select #(
    .N  (FU_NUM),
    .W  (CDB_WIDTH),
    .PW (PW)
  ) u_select (
    .req      (req),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .lane_sel (lane_sel),
    .next_ptr (next_ptr)
  );

  // Slot state: capture beats release; a squash empties speculative slots; clear drops br_tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending  <= '0;
      slot_pkt <= '0;
      rr_ptr   <= '0;
    end else begin
      for (int k = 0; k < FU_NUM; k++) begin
        if (capture[k]) begin
          pending[k]  <= 1'b1;
          slot_pkt[k] <= fu_pkt_i[k];
          if (clear_now) slot_pkt[k].br_tag <= 1'b0;
        end else if (grant[k] || (squash_i && slot_br[k])) begin
          pending[k] <= 1'b0;
        end else if (clear_now) begin
          slot_pkt[k].br_tag <= 1'b0;
        end
      end
      rr_ptr <= next_ptr;
    end
  end

  // Lane mux from the one-hot selects; an unselected lane stays all-zero.
  always_comb begin
    lane_valid = '0;
    lane_tag   = '0;
    lane_value = '0;
    lane_rob   = '0;
    for (int w = 0; w < CDB_WIDTH; w++) begin
      for (int k = 0; k < FU_NUM; k++) begin
        if (lane_sel[w][k]) begin
          lane_valid[w] = 1'b1;
          lane_tag[w]   = TAG_W'(slot_pkt[k].tag);
          lane_value[w] = XLEN'(slot_pkt[k].value);
          lane_rob[w]   = ROB_W'(slot_pkt[k].rob_idx);
        end
      end
    end
  end

  // Broadcast registers: one-cycle pulse per granted result.
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_valid_o   <= '0;
      cdb_tag_o     <= '0;
      cdb_value_o   <= '0;
      cdb_rob_idx_o <= '0;
    end else begin
      cdb_valid_o   <= lane_valid;
      cdb_tag_o     <= lane_tag;
      cdb_value_o   <= lane_value;
      cdb_rob_idx_o <= lane_rob;
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb/tb_cdb_broadcaster.sv - directed and randomized bench with behavioural reference model
module tb_cdb_broadcaster;
  import cdb_broadcaster_pkg::*;

  localparam int FN = 4;
  localparam int CW = 2;

  logic                             clock = 1'b0;
  logic                             reset;
  logic [FN-1:0]                    fu_valid_i;
  cdb_packet_t [FN-1:0]             fu_pkt_i;
  logic [FN-1:0]                    fu_ready_o;
  logic                             squash_i;
  logic                             clear_br_tag_i;
  logic [CW-1:0]                    cdb_valid_o;
  logic [CW-1:0][CDB_TAG_W-1:0]     cdb_tag_o;
  logic [CW-1:0][CDB_XLEN-1:0]      cdb_value_o;
  logic [CW-1:0][CDB_ROB_W-1:0]     cdb_rob_idx_o;

  cdb_broadcaster #(
    .PHYS_REGS (CDB_PHYS_REGS),
    .ROB_DEPTH (CDB_ROB_DEPTH),
    .XLEN      (CDB_XLEN),
    .FU_NUM    (FN),
    .CDB_WIDTH (CW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .fu_valid_i     (fu_valid_i),
    .fu_pkt_i       (fu_pkt_i),
    .fu_ready_o     (fu_ready_o),
    .squash_i       (squash_i),
    .clear_br_tag_i (clear_br_tag_i),
    .cdb_valid_o    (cdb_valid_o),
    .cdb_tag_o      (cdb_tag_o),
    .cdb_value_o    (cdb_value_o),
    .cdb_rob_idx_o  (cdb_rob_idx_o)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: slot contents, fairness pointer and expected broadcast.
  bit                           m_pend [FN];
  cdb_packet_t                  m_pkt  [FN];
  int                           m_rr;
  logic [CW-1:0]                e_valid;
  logic [CW-1:0][CDB_TAG_W-1:0] e_tag;
  logic [CW-1:0][CDB_XLEN-1:0]  e_value;
  logic [CW-1:0][CDB_ROB_W-1:0] e_rob;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic idle();
    fu_valid_i     = '0;
    fu_pkt_i       = '0;
    squash_i       = 1'b0;
    clear_br_tag_i = 1'b0;
  endtask

  task automatic drive(input int k, input int tag, input int val, input int rob, input bit br);
    fu_valid_i[k]         = 1'b1;
    fu_pkt_i[k].tag       = CDB_TAG_W'(tag);
    fu_pkt_i[k].value     = CDB_XLEN'(val);
    fu_pkt_i[k].rob_idx   = CDB_ROB_W'(rob);
    fu_pkt_i[k].br_tag    = br;
  endtask

  // One clock: check ready before the edge, advance the model, check the broadcast after it.
  task automatic cycle();
    bit                   gr [FN];
    bit                   lv [CW];
    cdb_packet_t          lp [CW];
    logic [FN-1:0]        exp_rdy;
    logic [FN-1:0]        v_in;
    cdb_packet_t [FN-1:0] p_in;
    logic                 sq, cl, rs;
    int                   cnt, last, k;
    #2;
    v_in = fu_valid_i; p_in = fu_pkt_i; sq = squash_i; cl = clear_br_tag_i; rs = reset;
    cnt = 0; last = -1;
    for (int w = 0; w < CW; w++) begin lv[w] = 1'b0; lp[w] = '0; end
    for (int j = 0; j < FN; j++) gr[j] = 1'b0;
    for (int i = 0; i < FN; i++) begin
      k = (m_rr + i) % FN;
      if (m_pend[k] && !(sq && m_pkt[k].br_tag) && cnt < CW) begin
        gr[k] = 1'b1; lv[cnt] = 1'b1; lp[cnt] = m_pkt[k]; cnt++; last = k;
      end
    end
    for (int j = 0; j < FN; j++) exp_rdy[j] = !m_pend[j] || gr[j];
    chk("fu_ready", 64'(fu_ready_o), 64'(exp_rdy));
    @(posedge clock);
    #1;
    if (rs) begin
      for (int j = 0; j < FN; j++) begin m_pend[j] = 1'b0; m_pkt[j] = '0; end
      m_rr = 0;
      e_valid = '0; e_tag = '0; e_value = '0; e_rob = '0;
    end else begin
      for (int j = 0; j < FN; j++) begin
        if (v_in[j] && exp_rdy[j] && !(sq && p_in[j].br_tag)) begin
          m_pend[j] = 1'b1;
          m_pkt[j]  = p_in[j];
          if (cl && !sq) m_pkt[j].br_tag = 1'b0;
        end else if (gr[j] || (sq && m_pkt[j].br_tag)) begin
          m_pend[j] = 1'b0;
        end else if (cl && !sq) begin
          m_pkt[j].br_tag = 1'b0;
        end
      end
      if (last >= 0) m_rr = (last + 1) % FN;
      for (int w = 0; w < CW; w++) begin
        e_valid[w] = lv[w];
        e_tag[w]   = lv[w] ? lp[w].tag     : '0;
        e_value[w] = lv[w] ? lp[w].value   : '0;
        e_rob[w]   = lv[w] ? lp[w].rob_idx : '0;
      end
    end
    chk("cdb_valid",   64'(cdb_valid_o),   64'(e_valid));
    chk("cdb_tag",     64'(cdb_tag_o),     64'(e_tag));
    chk("cdb_value",   64'(cdb_value_o),   64'(e_value));
    chk("cdb_rob_idx", 64'(cdb_rob_idx_o), 64'(e_rob));
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int seen_bcast;
    idle();
    reset = 1'b1;
    for (int j = 0; j < FN; j++) begin m_pend[j] = 1'b0; m_pkt[j] = '0; end
    m_rr = 0; e_valid = '0; e_tag = '0; e_value = '0; e_rob = '0;
    @(posedge clock);
    #1;
    cycle();
    reset = 1'b0;
    chk("reset_valid", 64'(cdb_valid_o), 64'h0);
    chk("reset_ready", 64'(fu_ready_o), 64'hF);

    // Single result on FU2, visible two edges later in lane 0.
    drive(2, 37, 32'h0000_BEEF, 5, 1'b0);
    cycle();
    idle();
    cycle();
    chk("single_valid", 64'(cdb_valid_o), 64'h1);
    chk("single_tag", 64'(cdb_tag_o[0]), 64'd37);
    chk("single_rob", 64'(cdb_rob_idx_o[0]), 64'd5);
    chk("single_value", 64'(cdb_value_o[0]), 64'h0000_BEEF);
    cycle();
    chk("single_once", 64'(cdb_valid_o), 64'h0);

    // Contention from a fresh pointer: FU0,FU1 first, then FU2,FU3.
    do_reset();
    for (int k = 0; k < FN; k++) drive(k, 10 + k, 100 + k, 20 + k, 1'b0);
    cycle();
    idle();
    #1;
    chk("contend_ready", 64'(fu_ready_o), 64'h3);
    cycle();
    chk("contend_a_valid", 64'(cdb_valid_o), 64'h3);
    chk("contend_a_tag0", 64'(cdb_tag_o[0]), 64'd10);
    chk("contend_a_tag1", 64'(cdb_tag_o[1]), 64'd11);
    cycle();
    chk("contend_b_valid", 64'(cdb_valid_o), 64'h3);
    chk("contend_b_tag0", 64'(cdb_tag_o[0]), 64'd12);
    chk("contend_b_tag1", 64'(cdb_tag_o[1]), 64'd13);
    cycle();
    chk("contend_done", 64'(cdb_valid_o), 64'h0);

    // Squash: FU1 speculative is discarded, FU2 survives, new FU1 speculative is dropped.
    drive(1, 21, 1, 1, 1'b1);
    drive(2, 22, 2, 2, 1'b0);
    cycle();
    idle();
    squash_i = 1'b1;
    drive(1, 29, 9, 9, 1'b1);
    cycle();
    idle();
    chk("squash_valid", 64'(cdb_valid_o), 64'h1);
    chk("squash_tag", 64'(cdb_tag_o[0]), 64'd22);
    seen_bcast = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (cdb_valid_o != '0) seen_bcast++;
    end
    chk("squash_no_late", 64'(seen_bcast), 64'd0);

    // Clear on capture makes FU0 survive a later squash.
    drive(0, 40, 4, 4, 1'b1);
    clear_br_tag_i = 1'b1;
    cycle();
    idle();
    squash_i = 1'b1;
    cycle();
    idle();
    chk("clear_keep_valid", 64'(cdb_valid_o), 64'h1);
    chk("clear_keep_tag", 64'(cdb_tag_o[0]), 64'd40);

    // Squash and clear together: squash wins.
    drive(1, 41, 5, 6, 1'b1);
    cycle();
    idle();
    squash_i = 1'b1;
    clear_br_tag_i = 1'b1;
    cycle();
    idle();
    chk("sq_and_clr_a", 64'(cdb_valid_o), 64'h0);
    cycle();
    chk("sq_and_clr_b", 64'(cdb_valid_o), 64'h0);

    // Reset with three slots pending discards everything.
    drive(0, 50, 0, 0, 1'b0);
    drive(1, 51, 0, 0, 1'b0);
    drive(3, 53, 0, 0, 1'b0);
    cycle();
    do_reset();
    chk("midreset_valid", 64'(cdb_valid_o), 64'h0);
    chk("midreset_ready", 64'(fu_ready_o), 64'hF);
    seen_bcast = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (cdb_valid_o != '0) seen_bcast++;
    end
    chk("midreset_quiet", 64'(seen_bcast), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int k = 0; k < FN; k++) begin
        if ($urandom_range(0, 2) != 0)
          drive(k, int'($urandom_range(0, CDB_PHYS_REGS - 1)), int'($urandom),
                int'($urandom_range(0, CDB_ROB_DEPTH - 1)), bit'($urandom_range(0, 1)));
      end
      squash_i       = ($urandom_range(0, 7) == 0);
      clear_br_tag_i = ($urandom_range(0, 7) == 0);
      reset          = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_broadcaster.md
# cdb_broadcaster

Completion-side transmitter of the common data bus. It collects results from FU_NUM functional units into per-FU one-entry holding slots. Each cycle it grants up to CDB_WIDTH pending slots in round-robin order and drives the registered cdb_valid/cdb_tag broadcast that every RS entry, map table and ROB snoops for wakeup and completion. It also applies the same branch-tag squash/clear protocol the RS uses.

## Interface
Parameters:
- PHYS_REGS, 128, physical register count; tag width $clog2(PHYS_REGS)
- ROB_DEPTH, 64, ROB entries; rob_idx width $clog2(ROB_DEPTH)
- XLEN, 32, result width
- FU_NUM, 4, number of completing FUs
- CDB_WIDTH, 2, broadcast lanes per cycle (1 ≤ CDB_WIDTH ≤ FU_NUM)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- fu_valid_i  in  FU_NUM  FU k presents a result this cycle
- fu_pkt_i  in  FU_NUM × cdb_packet_t  per-FU result: tag, value, rob_idx, br_tag
- fu_ready_o  out  FU_NUM  slot k can capture this cycle
- squash_i  in  1  branch mispredict; discard every br_tag=1 result
- clear_br_tag_i  in  1  branch resolved correct; clear br_tag on all held results
- cdb_valid_o  out  CDB_WIDTH  lane valid
- cdb_tag_o  out  CDB_WIDTH × tag  destination physical tag
- cdb_value_o  out  CDB_WIDTH × XLEN  result value
- cdb_rob_idx_o  out  CDB_WIDTH × rob_idx  completing ROB index

## Operation
- Slot k state: pending bit plus a cdb_packet_t.
- Capture: fu_valid_i[k] && fu_ready_o[k] loads slot k at the clock edge and sets pending. When fu_ready_o[k]=0, the FU holds its result.
- fu_ready_o[k] = !pending[k] || grant[k]. This is combinational and allows one result per cycle per FU at full throughput.
- Arbitration, combinational in cycle t:
  - Requests: req = pending & ~(squash_i ? br_tag : 0).
  - Scan from rr_ptr upward, modulo FU_NUM.
  - Grant the first CDB_WIDTH requesters.
  - Grants fill lanes 0,1,… contiguously in scan order; unused lanes are invalid.
- Granted slots clear pending at the edge, unless they recapture the same edge.
- rr_ptr: if any grant, rr_ptr ← (last granted index + 1) mod FU_NUM; otherwise it holds.
- Output registers load the lane packets at the edge. An invalid lane forces valid=0, tag=0, value=0, rob_idx=0.
- Squash (squash_i=1):
  - Every slot with br_tag=1 clears pending and is not granted.
  - An incoming fu_pkt_i with br_tag=1 is dropped; fu_ready_o stays as defined.
  - Slots with br_tag=0 arbitrate normally.
- Clear (clear_br_tag_i=1 and squash_i=0): br_tag←0 on all pending slots and on packets captured that edge.
- squash_i and clear_br_tag_i asserted together: squash wins; no clear is applied.
- No duplicate-tag checking; tags are broadcast verbatim.

## Timing
- Reset state: all slots empty, rr_ptr=0, all cdb outputs 0. fu_ready_o = all ones, combinational on the empty slots.
- Latency, minimum 2 cycles:
  - FU valid in cycle t is captured at the end of t.
  - It arbitrates in t+1.
  - The broadcast is visible during t+2.
- An ungranted slot waits. Round-robin bounds the wait to ⌈FU_NUM/CDB_WIDTH⌉ − 1 extra cycles.
- cdb_valid_o is high for exactly one cycle per result. The broadcast is never repeated and never held.
- Squash acts on slot contents in the squash cycle. A result already in the output registers is still broadcast the following cycle; the ROB/RS squash handles it.
- Reset mid-operation: all pending results are discarded. Outputs are zero from the cycle after the reset edge.

## Structure
- cdb_packet_t (tag, value, rob_idx, br_tag) lives in def.svh beside rs_entry_t. The CDB lane consumers read the same typedef.
- Sub-module rr_multi_select: inputs are the request vector, rr_ptr and CDB_WIDTH; outputs are the grant vector, per-lane one-hot select, and next pointer. It is purely combinational and reusable for issue select.
- The top holds the slots, rr_ptr, output registers, and squash/clear logic.

## Test plan
- Single result: after reset, FU2 presents tag=37, rob_idx=5 → cycle+2 shows lane0 valid, tag=37, rob_idx=5, lane1 invalid; rr_ptr=3.
- Contention: FU0–FU3 all valid in the same cycle, CDB_WIDTH=2 → first broadcast is FU0,FU1 in lanes 0,1; next is FU2,FU3. fu_ready_o[2:3]=0 for one cycle.
- Fairness: FU0 and FU3 continuously valid, CDB_WIDTH=1 → broadcasts alternate 0,3,0,3; neither waits more than 1 extra cycle.
- Squash: slots FU1 (br_tag=1) and FU2 (br_tag=0) pending, squash_i=1 → only FU2 is broadcast. FU1's slot is empty, and an incoming FU1 br_tag=1 result in the same cycle never appears.
- Clear then squash: FU0 held with br_tag=1, clear_br_tag_i pulse, then squash_i → FU0 is still broadcast. Squash and clear asserted together drop br_tag=1 slots.
- Reset mid-flight: three slots pending, reset asserted one cycle → no broadcasts follow, all fu_ready_o=1, rr_ptr=0.
